// File: rtl/param_sys_array.sv
// Output-stationary systolic tile computing C = A x B one inner-product index per beat.
// The finished tile is held on a valid/ready port, with an optional sum of all C entries.
module param_sys_array #(
   parameter int WIDTH = 8,
   parameter int ROWS  = 2,
   parameter int COLS  = 2,
   parameter int DEPTH = 4,
   localparam int ACC_W = 2*WIDTH + $clog2(DEPTH),
   localparam int IMP_W = ACC_W + $clog2(ROWS*COLS)
) (
   input  logic                         clk,
   input  logic                         _reset,
   input  logic                         enable,
   input  logic                         abort,
   input  logic                         imp_en,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ROWS*WIDTH-1:0]        a_col,
   input  logic [COLS*WIDTH-1:0]        b_row,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ROWS*COLS*ACC_W-1:0]   result,
   output logic signed [IMP_W-1:0]      importance
);

   localparam int KW = $clog2(DEPTH);

   typedef enum logic {
      ACC  = 1'b0,
      DONE = 1'b1
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [KW-1:0]           k_cnt;
   logic                    imp_flag;
   logic                    accept;
   logic                    first_beat;
   logic                    last_beat;
   logic signed [ACC_W-1:0] acc  [ROWS][COLS];
   logic signed [2*WIDTH-1:0] prod [ROWS][COLS];
   logic signed [IMP_W-1:0] acc_sum;

   // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
   // a result transfers on a rising edge where out_valid && out_ready && enable.
   assign in_ready   = enable && (state == ACC);
   assign accept     = in_valid && in_ready;
   assign first_beat = (k_cnt == '0);
   assign last_beat  = (k_cnt == KW'(DEPTH-1));
   assign out_valid  = (state == DONE);

   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            prod[r][c] = $signed(a_col[r*WIDTH +: WIDTH]) * $signed(b_row[c*WIDTH +: WIDTH]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!_reset) begin
         state <= ACC;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = ACC;
      end else if (enable) begin
         case (state)
            ACC:     if (accept && last_beat) state_next = DONE;
            DONE:    if (out_ready) state_next = ACC;
            default: state_next = ACC;
         endcase
      end
   end

   // The k=0 beat overwrites the accumulators, so no clear cycle is needed between tiles.
   always_ff @(posedge clk) begin
      if (!_reset) begin
         k_cnt    <= '0;
         imp_flag <= 1'b0;
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               acc[r][c] <= '0;
            end
         end
      end else if (abort) begin
         k_cnt    <= '0;
         imp_flag <= 1'b0;
      end else if (accept) begin
         k_cnt <= last_beat ? '0 : k_cnt + 1'b1;
         if (first_beat) imp_flag <= imp_en;
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               if (first_beat) acc[r][c] <= ACC_W'(prod[r][c]);
               else            acc[r][c] <= acc[r][c] + ACC_W'(prod[r][c]);
            end
         end
      end
   end

   always_comb begin
      result  = '0;
      acc_sum = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            result[(r*COLS+c)*ACC_W +: ACC_W] = acc[r][c];
            acc_sum = acc_sum + IMP_W'(acc[r][c]);
         end
      end
      importance = (out_valid && imp_flag) ? acc_sum : '0;
   end

endmodule

// File: tb/tb_param_sys_array.sv
// Directed bench for param_sys_array: default 2x2x4 tile plus a 3x4x8 tile against a golden model.
module tb_param_sys_array;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   // default instance: ACC_W=18, IMP_W=20
   logic        enable, abort, imp_en, in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a_col, b_row;
   logic [71:0] result;
   logic [19:0] importance;

   // large instance: ROWS=3, COLS=4, DEPTH=8 -> ACC_W=19, IMP_W=23
   logic         en2, abort2, imp_en2, in_valid2, in_ready2, out_valid2, out_ready2;
   logic [23:0]  a_col2;
   logic [31:0]  b_row2;
   logic [227:0] result2;
   logic [22:0]  importance2;
   logic [18:0]  exp_q[$];

   logic [15:0] t1_a[4] = '{16'h0501, 16'h0602, 16'h0703, 16'h0804};
   logic [15:0] t1_b[4] = '{16'h0101, 16'hFF01, 16'h0101, 16'hFF01};

   always #5 clk = ~clk;

   param_sys_array dut (
      .clk(clk), ._reset(rst_n), .enable(enable), .abort(abort), .imp_en(imp_en),
      .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .importance(importance)
   );

   param_sys_array #(.WIDTH(8), .ROWS(3), .COLS(4), .DEPTH(8)) dut2 (
      .clk(clk), ._reset(rst_n), .enable(en2), .abort(abort2), .imp_en(imp_en2),
      .in_valid(in_valid2), .in_ready(in_ready2), .a_col(a_col2), .b_row(b_row2),
      .out_valid(out_valid2), .out_ready(out_ready2), .result(result2), .importance(importance2)
   );

   function automatic logic [71:0] pack4(input int c00, input int c01, input int c10, input int c11);
      logic [71:0] p;
      p[0  +: 18] = 18'(c00);
      p[18 +: 18] = 18'(c01);
      p[36 +: 18] = 18'(c10);
      p[54 +: 18] = 18'(c11);
      return p;
   endfunction

   task automatic drive_beat(input logic [15:0] a, input logic [15:0] b, input logic imp);
      @(negedge clk);
      enable   = 1'b1;
      a_col    = a;
      b_row    = b;
      imp_en   = imp;
      in_valid = 1'b1;
   endtask

   task automatic go_idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_t1(input logic imp);
      for (int k = 0; k < 4; k++) drive_beat(t1_a[k], t1_b[k], imp);
      go_idle();
   endtask

   task automatic accept_result();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (result !== 72'd0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
      checks++;
      if (importance !== 20'd0) begin failures++; $display("FAIL reset_importance: got %h expected 0", importance); end
      checks++;
      if (out_valid2 !== 1'b0 || result2 !== 228'd0) begin failures++; $display("FAIL reset_dut2: got valid=%b result=%h expected 0", out_valid2, result2); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      for (int k = 0; k < 4; k++) drive_beat(t1_a[k], t1_b[k], 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
      go_idle();
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency: got %b expected 1", out_valid); end
      checks++;
      if (result !== pack4(10, -2, 26, -2)) begin failures++; $display("FAIL basic_result: got %h expected %h", result, pack4(10, -2, 26, -2)); end
      checks++;
      if (importance !== 20'(32)) begin failures++; $display("FAIL basic_importance: got %0d expected 32", $signed(importance)); end
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_done: got %b expected 0", in_ready); end
      accept_result();
      checks++;
      if (out_valid !== 1'b0 || importance !== 20'd0) begin failures++; $display("FAIL basic_release: got valid=%b imp=%h expected 0/0", out_valid, importance); end
   endtask

   task automatic test_overflow();
      for (int k = 0; k < 4; k++) drive_beat(16'h8080, 16'h8080, 1'b1);
      go_idle();
      checks++;
      if (result !== pack4(65536, 65536, 65536, 65536)) begin failures++; $display("FAIL ovf_neg_neg: got %h expected %h", result, pack4(65536, 65536, 65536, 65536)); end
      checks++;
      if (importance !== 20'(262144)) begin failures++; $display("FAIL ovf_imp_pos: got %0d expected 262144", $signed(importance)); end
      accept_result();
      for (int k = 0; k < 4; k++) drive_beat(16'h8080, 16'h7F7F, 1'b1);
      go_idle();
      checks++;
      if (result !== pack4(-65024, -65024, -65024, -65024)) begin failures++; $display("FAIL ovf_neg_pos: got %h expected %h", result, pack4(-65024, -65024, -65024, -65024)); end
      checks++;
      if (importance !== 20'(-260096)) begin failures++; $display("FAIL ovf_imp_neg: got %0d expected -260096", $signed(importance)); end
      accept_result();
   endtask

   task automatic test_back_to_back();
      run_t1(1'b0);
      a_col    = t1_a[0];
      b_row    = t1_b[0];
      imp_en   = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_%0d: got ready=%b valid=%b expected 0/1", i, in_ready, out_valid); end
         checks++;
         if (result !== pack4(10, -2, 26, -2)) begin failures++; $display("FAIL bp_stable_%0d: got %h expected %h", i, result, pack4(10, -2, 26, -2)); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
      for (int k = 1; k < 4; k++) drive_beat(t1_a[k], t1_b[k], 1'b1);
      go_idle();
      checks++;
      if (out_valid !== 1'b1 || result !== pack4(10, -2, 26, -2)) begin failures++; $display("FAIL bp_next_tile: got valid=%b result=%h expected 1/%h", out_valid, result, pack4(10, -2, 26, -2)); end
      checks++;
      if (importance !== 20'(32)) begin failures++; $display("FAIL bp_next_imp: got %0d expected 32", $signed(importance)); end
      accept_result();
   endtask

   task automatic test_enable();
      drive_beat(t1_a[0], t1_b[0], 1'b1);
      drive_beat(t1_a[1], t1_b[1], 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         enable   = 1'b0;
         a_col    = t1_a[2];
         b_row    = t1_b[2];
         in_valid = 1'b1;
         #1;
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL en_freeze_%0d: got ready=%b valid=%b expected 0/0", i, in_ready, out_valid); end
         checks++;
         if (result !== pack4(3, -1, 11, -1)) begin failures++; $display("FAIL en_partial_%0d: got %h expected %h", i, result, pack4(3, -1, 11, -1)); end
      end
      drive_beat(t1_a[2], t1_b[2], 1'b1);
      drive_beat(t1_a[3], t1_b[3], 1'b1);
      go_idle();
      checks++;
      if (out_valid !== 1'b1 || result !== pack4(10, -2, 26, -2) || importance !== 20'(32)) begin
         failures++;
         $display("FAIL en_result: got valid=%b result=%h imp=%0d expected 1/%h/32", out_valid, result, $signed(importance), pack4(10, -2, 26, -2));
      end
      accept_result();
   endtask

   task automatic test_abort();
      drive_beat(t1_a[0], t1_b[0], 1'b1);
      drive_beat(t1_a[1], t1_b[1], 1'b1);
      @(negedge clk);
      abort    = 1'b1;
      a_col    = t1_a[2];
      b_row    = t1_b[2];
      in_valid = 1'b1;
      @(negedge clk);
      abort    = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL abort_state: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
      checks++;
      if (result !== pack4(3, -1, 11, -1)) begin failures++; $display("FAIL abort_keep: got %h expected %h", result, pack4(3, -1, 11, -1)); end
      run_t1(1'b1);
      checks++;
      if (out_valid !== 1'b1 || result !== pack4(10, -2, 26, -2) || importance !== 20'(32)) begin
         failures++;
         $display("FAIL abort_retile: got valid=%b result=%h imp=%0d expected 1/%h/32", out_valid, result, $signed(importance), pack4(10, -2, 26, -2));
      end
      accept_result();
      for (int k = 0; k < 3; k++) drive_beat(t1_a[k], t1_b[k], 1'b1);
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || result !== 72'd0 || importance !== 20'd0) begin
         failures++;
         $display("FAIL midreset_clear: got valid=%b result=%h imp=%h expected 0/0/0", out_valid, result, importance);
      end
      rst_n = 1'b1;
      run_t1(1'b1);
      checks++;
      if (out_valid !== 1'b1 || result !== pack4(10, -2, 26, -2)) begin failures++; $display("FAIL midreset_retile: got valid=%b result=%h expected 1/%h", out_valid, result, pack4(10, -2, 26, -2)); end
      accept_result();
   endtask

   task automatic test_large();
      int ga[3][8];
      int gb[8][4];
      int sum;
      int imp_sum;
      logic [18:0] exp_v;
      for (int t = 0; t < 2; t++) begin
         imp_sum = 0;
         for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < 3; r++) ga[r][k] = int'($urandom_range(0, 255)) - 128;
            for (int c = 0; c < 4; c++) gb[k][c] = int'($urandom_range(0, 255)) - 128;
         end
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
               sum = 0;
               for (int k = 0; k < 8; k++) sum += ga[r][k] * gb[k][c];
               imp_sum += sum;
               exp_q.push_back(19'(sum));
            end
         end
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            for (int r = 0; r < 3; r++) a_col2[r*8 +: 8] = 8'(ga[r][k]);
            for (int c = 0; c < 4; c++) b_row2[c*8 +: 8] = 8'(gb[k][c]);
            imp_en2   = (t == 1);
            in_valid2 = 1'b1;
         end
         @(negedge clk);
         in_valid2 = 1'b0;
         checks++;
         if (out_valid2 !== 1'b1) begin failures++; $display("FAIL large_valid_t%0d: got %b expected 1", t, out_valid2); end
         for (int i = 0; i < 12; i++) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (result2[i*19 +: 19] !== exp_v) begin failures++; $display("FAIL large_c%0d_t%0d: got %0d expected %0d", i, t, $signed(result2[i*19 +: 19]), $signed(exp_v)); end
         end
         checks++;
         if (importance2 !== ((t == 1) ? 23'(imp_sum) : 23'd0)) begin
            failures++;
            $display("FAIL large_imp_t%0d: got %0d expected %0d", t, $signed(importance2), (t == 1) ? imp_sum : 0);
         end
         out_ready2 = 1'b1;
         @(negedge clk);
         out_ready2 = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b1; abort = 1'b0; imp_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a_col = '0; b_row = '0;
      en2 = 1'b1; abort2 = 1'b0; imp_en2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
      a_col2 = '0; b_row2 = '0;
      test_reset();
      test_basic();
      test_overflow();
      test_back_to_back();
      test_enable();
      test_abort();
      test_large();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
